// File: rtl/phase_pkg.sv
// Shared types and helpers for the multi-channel phase averager.
package phase_pkg;

    typedef logic signed [31:0] q24_8_t;
    // Phase differences and sums need two guard bits before wrapping.
    typedef logic signed [33:0] phase_ext_t;

    localparam int PHASE_HALF = 46080;    // 180 degrees in Q24.8
    localparam int PHASE_FULL = 92160;    // 360 degrees in Q24.8

    // Channel state is sized for the largest supported run length, so one
    // struct type serves every RUNS_LOG2 setting.
    localparam int RUNS_LOG2_MAX = 8;
    localparam int CNT_W         = RUNS_LOG2_MAX + 1;
    localparam int ACC_W         = 32 + RUNS_LOG2_MAX;
    localparam int DROP_W        = 16;

    typedef struct packed {
        logic [CNT_W-1:0]        cnt;
        q24_8_t                  ref_ph;
        logic signed [ACC_W-1:0] acc_ph;
        logic [ACC_W-1:0]        acc_fr;
        logic [DROP_W-1:0]       drop;
    } chan_state_t;

    // Fold a phase into [-180,180) degrees; operands are always within one
    // turn of that range, so a single correction is enough.
    function automatic q24_8_t wrap_phase(input phase_ext_t x);
        if (x >= phase_ext_t'(PHASE_HALF))
            return q24_8_t'(x - phase_ext_t'(PHASE_FULL));
        else if (x < -phase_ext_t'(PHASE_HALF))
            return q24_8_t'(x + phase_ext_t'(PHASE_FULL));
        else
            return q24_8_t'(x);
    endfunction

endpackage

// File: rtl/phase_acc_bank.sv
// Per-channel accumulator bank: S2 state update and completion detect.
module phase_acc_bank
    import phase_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int RUNS_LOG2 = 3,
    parameter int MAG_MIN   = 256,
    parameter int CH_W      = 2
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            rec_vld,    // S2 holds a record for an existing channel
    input  logic            advance,    // S2 is not stalled this cycle
    input  logic [CH_W-1:0] rec_ch,
    input  logic [31:0]     rec_freq,
    input  q24_8_t          rec_mag,
    input  q24_8_t          rec_d,
    output logic            done,
    output q24_8_t          res_phase,
    output logic [31:0]     res_freq,
    output logic [15:0]     res_drop
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << RUNS_LOG2);

    chan_state_t             state_q [CHANNELS];
    chan_state_t             state_d [CHANNELS];
    chan_state_t             cur;
    chan_state_t             nxt;
    logic                    qualify;
    logic [CNT_W-1:0]        cnt_n;
    logic signed [ACC_W-1:0] acc_ph_n;
    logic [ACC_W-1:0]        acc_fr_n;

    // Read-modify-write of the addressed channel plus result formation.
    always_comb begin
        state_d  = state_q;
        cur      = state_q[rec_ch];
        nxt      = cur;
        cnt_n    = cur.cnt;
        acc_ph_n = cur.acc_ph;
        acc_fr_n = cur.acc_fr;
        qualify  = (rec_mag >= q24_8_t'(MAG_MIN));

        if (!qualify) begin
            nxt.drop = (cur.drop == '1) ? cur.drop : cur.drop + 1'b1;
        end else if (cur.cnt == '0) begin
            // First record of a batch becomes the reference; later records
            // accumulate their wrapped offset from it so the mean never
            // straddles the +/-180 seam.
            nxt.ref_ph = rec_d;
            acc_ph_n   = '0;
            acc_fr_n   = ACC_W'(rec_freq);
            cnt_n      = CNT_W'(1);
        end else begin
            acc_ph_n = cur.acc_ph + ACC_W'(wrap_phase(phase_ext_t'(rec_d) - phase_ext_t'(cur.ref_ph)));
            acc_fr_n = cur.acc_fr + ACC_W'(rec_freq);
            cnt_n    = cur.cnt + 1'b1;
        end

        nxt.cnt    = cnt_n;
        nxt.acc_ph = acc_ph_n;
        nxt.acc_fr = acc_fr_n;

        done      = rec_vld && qualify && (cnt_n == CNT_FULL);
        res_phase = wrap_phase(phase_ext_t'(nxt.ref_ph) + phase_ext_t'(acc_ph_n >>> RUNS_LOG2));
        res_freq  = 32'(acc_fr_n >> RUNS_LOG2);
        res_drop  = cur.drop;

        if (done)
            nxt = '0;
        if (rec_vld && advance)
            state_d[rec_ch] = nxt;
    end

    // Channel state registers; reset wipes any partial batch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++)
                state_q[i] <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/phase_average.sv
// Multi-channel wrap-aware phase/frequency averager with valid/ready ports.
module phase_average
    import phase_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int RUNS_LOG2 = 3,
    parameter int MAG_MIN   = 256,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            sink_valid,
    output logic            sink_ready,
    input  logic [CH_W-1:0] sink_channel,
    input  logic [31:0]     sink_freq,
    input  logic [31:0]     sink_mag,
    input  logic [31:0]     sink_phaseA,
    input  logic [31:0]     sink_phaseB,
    output logic            source_valid,
    input  logic            source_ready,
    output logic [CH_W-1:0] source_channel,
    output logic [31:0]     source_freq,
    output logic [31:0]     source_phase,
    output logic [15:0]     source_dropped
);

    logic            vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [CH_W-1:0] ch_p1_q, ch_p1_d, ch_p2_q, ch_p2_d;
    logic [31:0]     freq_p1_q, freq_p1_d, freq_p2_q, freq_p2_d;
    q24_8_t          mag_p1_q, mag_p1_d, mag_p2_q, mag_p2_d;
    q24_8_t          d_p1_q, d_p1_d, d_p2_q, d_p2_d;

    logic            src_vld_q, src_vld_d;
    logic [CH_W-1:0] src_ch_q, src_ch_d;
    logic [31:0]     src_freq_q, src_freq_d;
    q24_8_t          src_phase_q, src_phase_d;
    logic [15:0]     src_drop_q, src_drop_d;

    logic            rec_vld_p2, stall, accept, done;
    q24_8_t          res_phase;
    logic [31:0]     res_freq;
    logic [15:0]     res_drop;

    phase_acc_bank #(
        .CHANNELS  (CHANNELS),
        .RUNS_LOG2 (RUNS_LOG2),
        .MAG_MIN   (MAG_MIN),
        .CH_W      (CH_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .rec_vld   (rec_vld_p2),
        .advance   (!stall),
        .rec_ch    (ch_p2_q),
        .rec_freq  (freq_p2_q),
        .rec_mag   (mag_p2_q),
        .rec_d     (d_p2_q),
        .done      (done),
        .res_phase (res_phase),
        .res_freq  (res_freq),
        .res_drop  (res_drop)
    );

    // Handshake, stall propagation and next-state for S1, S2 and the output register.
    always_comb begin
        // Out-of-range channels flow through S2 without touching any state.
        rec_vld_p2 = vld_p2_q && (32'(ch_p2_q) < CHANNELS);
        stall      = done && src_vld_q && !source_ready;
        sink_ready = reset && !(vld_p1_q && stall);
        accept     = sink_valid && sink_ready;

        vld_p1_d  = vld_p1_q;
        ch_p1_d   = ch_p1_q;
        freq_p1_d = freq_p1_q;
        mag_p1_d  = mag_p1_q;
        d_p1_d    = d_p1_q;
        if (accept) begin
            vld_p1_d  = 1'b1;
            ch_p1_d   = sink_channel;
            freq_p1_d = sink_freq;
            mag_p1_d  = sink_mag;
            d_p1_d    = wrap_phase(phase_ext_t'($signed(sink_phaseA)) - phase_ext_t'($signed(sink_phaseB)));
        end else if (!stall) begin
            vld_p1_d  = 1'b0;
        end

        vld_p2_d  = vld_p2_q;
        ch_p2_d   = ch_p2_q;
        freq_p2_d = freq_p2_q;
        mag_p2_d  = mag_p2_q;
        d_p2_d    = d_p2_q;
        if (!stall) begin
            vld_p2_d  = vld_p1_q;
            ch_p2_d   = ch_p1_q;
            freq_p2_d = freq_p1_q;
            mag_p2_d  = mag_p1_q;
            d_p2_d    = d_p1_q;
        end

        // A completion reloads the output even while the old result is
        // being consumed, so back-to-back results leave no bubble.
        src_vld_d   = src_vld_q;
        src_ch_d    = src_ch_q;
        src_freq_d  = src_freq_q;
        src_phase_d = src_phase_q;
        src_drop_d  = src_drop_q;
        if (done && !stall) begin
            src_vld_d   = 1'b1;
            src_ch_d    = ch_p2_q;
            src_freq_d  = res_freq;
            src_phase_d = res_phase;
            src_drop_d  = res_drop;
        end else if (source_ready) begin
            src_vld_d   = 1'b0;
        end
    end

    // ---- S1/S2 valids and the output register (reset-controlled) ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            src_vld_q   <= 1'b0;
            src_ch_q    <= '0;
            src_freq_q  <= '0;
            src_phase_q <= '0;
            src_drop_q  <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            src_vld_q   <= src_vld_d;
            src_ch_q    <= src_ch_d;
            src_freq_q  <= src_freq_d;
            src_phase_q <= src_phase_d;
            src_drop_q  <= src_drop_d;
        end
    end

    // ---- S1/S2 record payload, qualified by the valids above ----
    always_ff @(posedge clk) begin
        ch_p1_q   <= ch_p1_d;
        freq_p1_q <= freq_p1_d;
        mag_p1_q  <= mag_p1_d;
        d_p1_q    <= d_p1_d;
        ch_p2_q   <= ch_p2_d;
        freq_p2_q <= freq_p2_d;
        mag_p2_q  <= mag_p2_d;
        d_p2_q    <= d_p2_d;
    end

    assign source_valid   = src_vld_q;
    assign source_channel = src_ch_q;
    assign source_freq    = src_freq_q;
    assign source_phase   = src_phase_q;
    assign source_dropped = src_drop_q;

endmodule
